ring_state_decoder: RTL and testbench
=====================================

// Module: ring_state_decoder
// PURPOSE
//   Receive-side checker/decoder for a rotating one-hot ring counter bus.
//   Samples the ring word, converts it to a binary index and verifies one-hot
//   validity and rotate-left sequencing (bit i -> bit i+1, MSB -> bit 0).
//   Counts completed laps. Sits downstream of the ring counter as its monitor.
// PARAMETERS
//   WIDTH  3  ring width in bits; legal range WIDTH >= 2
//   CNT_W  8  lap counter width
//   IDX_W  (localparam) $clog2(WIDTH); binary index width
// PORTS
//   clk         in   1      clock, rising edge
//   rst         in   1      reset, asynchronous, active-high
//   in_valid    in   1      ring_in is valid this cycle; one sample per valid cycle
//   ring_in     in   WIDTH  one-hot ring word
//   clr_err     in   1      clears err_sticky
//   idx_out     out  IDX_W  binary position of the set bit
//   idx_valid   out  1      idx_out updated from a good sample; 1-cycle pulse
//   onehot_err  out  1      sample was zero or had >1 bit set; 1-cycle pulse
//   seq_err     out  1      valid one-hot but not rotate-left of last good; pulse
//   err_sticky  out  1      set on any error, held until clr_err
//   lap_pulse   out  1      wrap MSB -> bit0 observed; 1-cycle pulse
//   lap_count   out  CNT_W  completed laps, wraps modulo 2^CNT_W
//   locked      out  1      high in state TRACK
// BEHAVIOUR
//   Reset: all outputs 0, state SYNC, last-good register 0.
//   All outputs registered; response appears one clock after the in_valid
//     sample edge. in_valid=0: no checks, pulses low, all state held.
//   One-hot check: popcount(ring_in) == 1, else onehot_err in any state.
//   FSM:
//     SYNC : good one-hot sample -> idx_out/idx_valid, store last-good, ->TRACK.
//            No seq check and no lap in SYNC. Bad sample -> stay SYNC.
//     TRACK: expected = {last[WIDTH-2:0], last[WIDTH-1]}.
//            sample == expected -> idx_valid, update idx_out/last-good.
//              If last[WIDTH-1] & sample[0]: lap_pulse, lap_count+1.
//            bad one-hot -> onehot_err, -> SYNC.
//            good one-hot != expected -> seq_err, -> SYNC.
//   onehot_err and seq_err are mutually exclusive (one-hot check has priority).
//   On any error: idx_valid=0, idx_out holds previous value, lap_count held.
//   err_sticky: set by any error pulse; cleared by clr_err; same-cycle
//     error and clr_err -> set wins.
//   lap_count wrap: 2^CNT_W-1 + 1 -> 0, lap_pulse still asserted.
//   Repeated identical sample in TRACK (ring stalled) is a seq_err.
//   Async reset mid-operation: immediate return to reset values;
//     first post-reset sample handled as SYNC.
// TESTING
//   T1 rst pulse mid-stream -> all outputs 0, locked=0; next 001 gives idx 0.
//   T2 WIDTH=3: 001,010,100,001 on consecutive valid cycles -> idx 0,1,2,0;
//      locked from 1st; lap_pulse only on 4th; lap_count=1.
//   T3 locked, send 011 then 000 -> onehot_err both, locked=0, err_sticky=1,
//      idx_out holds last good value.
//   T4 locked at 001, send 100 -> seq_err=1, lap_pulse=0, SYNC; then
//      010,100 -> re-lock, no error.
//   T5 010, in_valid low 5 cycles, 100 -> no pulses during gap, idx 2,
//      no seq_err.
//   T6 CNT_W=2: 5 full laps -> lap_count 1,2,3,0,1; clr_err with
//      simultaneous seq_err -> err_sticky stays 1.

Source files
------------

// File: rtl/ring_state_decoder.sv
// ring_state_decoder
//   Receive-side monitor for a rotating one-hot ring counter bus. Each valid
//   sample is checked for one-hot validity and for rotate-left sequencing
//   against the last good sample. Good samples are converted to a binary index.
//   Completed laps (MSB -> bit 0 wrap) are counted.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   in_valid    in   ring_in carries a sample this cycle
//   ring_in     in   [WIDTH-1:0] one-hot ring word
//   clr_err     in   clears err_sticky; a same-cycle error still sets it
//   idx_out     out  [IDX_W-1:0] binary position of the last good sample
//   idx_valid   out  pulse: idx_out was refreshed from a good sample
//   onehot_err  out  pulse: the sample was zero or had more than one bit set
//   seq_err     out  pulse: valid one-hot that is not the rotate-left of last good
//   err_sticky  out  set by any error and held until clr_err
//   lap_pulse   out  pulse: an MSB -> bit 0 wrap was observed
//   lap_count   out  [CNT_W-1:0] completed laps, modulo 2^CNT_W
//   locked      out  high while tracking the ring sequence
module ring_state_decoder #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] ring_in,
    input  logic             clr_err,
    output logic [IDX_W-1:0] idx_out,
    output logic             idx_valid,
    output logic             onehot_err,
    output logic             seq_err,
    output logic             err_sticky,
    output logic             lap_pulse,
    output logic [CNT_W-1:0] lap_count,
    output logic             locked
);

    typedef enum logic {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               idx_valid_q, idx_valid_d;
    logic               onehot_err_q, onehot_err_d;
    logic               seq_err_q, seq_err_d;
    logic               err_sticky_q, err_sticky_d;
    logic               lap_pulse_q, lap_pulse_d;
    logic [CNT_W-1:0]   lap_count_q, lap_count_d;

    logic [WIDTH-1:0]   expected;
    logic               is_onehot;

    function automatic logic onehot_ok(input logic [WIDTH-1:0] w);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt += int'(w[i]);
        end
        return (cnt == 1);
    endfunction

    // Only called on a verified one-hot word, so OR-ing the set bit's
    // position yields exactly that position.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [WIDTH-1:0] w);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

    assign expected  = {last_q[WIDTH-2:0], last_q[WIDTH-1]};
    assign is_onehot = onehot_ok(ring_in);

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        idx_d        = idx_q;
        idx_valid_d  = 1'b0;
        onehot_err_d = 1'b0;
        seq_err_d    = 1'b0;
        lap_pulse_d  = 1'b0;
        lap_count_d  = lap_count_q;

        if (in_valid) begin
            if (!is_onehot) begin
                onehot_err_d = 1'b1;
                state_d      = SYNC;
            end else if (state_q == SYNC) begin
                // First good sample establishes the reference; no sequence or lap check yet.
                idx_valid_d = 1'b1;
                idx_d       = onehot_to_idx(ring_in);
                last_d      = ring_in;
                state_d     = TRACK;
            end else if (ring_in == expected) begin
                idx_valid_d = 1'b1;
                idx_d       = onehot_to_idx(ring_in);
                last_d      = ring_in;
                if (last_q[WIDTH-1] && ring_in[0]) begin
                    lap_pulse_d = 1'b1;
                    lap_count_d = lap_count_q + CNT_W'(1);
                end
            end else begin
                // Includes a stalled ring (same word repeated).
                seq_err_d = 1'b1;
                state_d   = SYNC;
            end
        end

        // Set has priority over clear.
        err_sticky_d = (err_sticky_q & ~clr_err) | onehot_err_d | seq_err_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SYNC;
            last_q       <= '0;
            idx_q        <= '0;
            idx_valid_q  <= 1'b0;
            onehot_err_q <= 1'b0;
            seq_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
            lap_pulse_q  <= 1'b0;
            lap_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            idx_q        <= idx_d;
            idx_valid_q  <= idx_valid_d;
            onehot_err_q <= onehot_err_d;
            seq_err_q    <= seq_err_d;
            err_sticky_q <= err_sticky_d;
            lap_pulse_q  <= lap_pulse_d;
            lap_count_q  <= lap_count_d;
        end
    end

    assign idx_out    = idx_q;
    assign idx_valid  = idx_valid_q;
    assign onehot_err = onehot_err_q;
    assign seq_err    = seq_err_q;
    assign err_sticky = err_sticky_q;
    assign lap_pulse  = lap_pulse_q;
    assign lap_count  = lap_count_q;
    assign locked     = (state_q == TRACK);

endmodule

// File: tb/tb_ring_state_decoder.sv
module tb_ring_state_decoder;

    localparam int WIDTH = 3;
    localparam int CNT_W = 2;
    localparam int IDX_W = $clog2(WIDTH);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] ring_in;
    logic             clr_err;
    logic [IDX_W-1:0] idx_out;
    logic             idx_valid;
    logic             onehot_err;
    logic             seq_err;
    logic             err_sticky;
    logic             lap_pulse;
    logic [CNT_W-1:0] lap_count;
    logic             locked;

    int total = 0;
    int bad   = 0;

    ring_state_decoder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .ring_in    (ring_in),
        .clr_err    (clr_err),
        .idx_out    (idx_out),
        .idx_valid  (idx_valid),
        .onehot_err (onehot_err),
        .seq_err    (seq_err),
        .err_sticky (err_sticky),
        .lap_pulse  (lap_pulse),
        .lap_count  (lap_count),
        .locked     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs; outputs are sampled 1ns after the edge.
    task automatic step(input logic v, input logic [WIDTH-1:0] r, input logic clr);
        in_valid = v;
        ring_in  = r;
        clr_err  = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ring_in  = '0;
        clr_err  = 1'b0;
    endtask

    // Compare the full output set: idx, idx_valid, onehot_err, seq_err, sticky, lap_pulse, lap_count, locked.
    task automatic check_all(input string tag, input int idx, input bit iv, input bit oe,
                             input bit se, input bit st, input bit lp, input int lc, input bit lk);
        check({tag, ".idx"},    32'(idx_out),    32'(idx));
        check({tag, ".ivld"},   32'(idx_valid),  32'(iv));
        check({tag, ".oherr"},  32'(onehot_err), 32'(oe));
        check({tag, ".seqerr"}, 32'(seq_err),    32'(se));
        check({tag, ".sticky"}, 32'(err_sticky), 32'(st));
        check({tag, ".lap"},    32'(lap_pulse),  32'(lp));
        check({tag, ".lapcnt"}, 32'(lap_count),  32'(lc));
        check({tag, ".locked"}, 32'(locked),     32'(lk));
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        ring_in  = '0;
        clr_err  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);

        // T2: clean lap from SYNC
        step(1'b1, 3'b001, 1'b0); check_all("t2a", 0, 1, 0, 0, 0, 0, 0, 1);
        step(1'b1, 3'b010, 1'b0); check_all("t2b", 1, 1, 0, 0, 0, 0, 0, 1);
        step(1'b1, 3'b100, 1'b0); check_all("t2c", 2, 1, 0, 0, 0, 0, 0, 1);
        step(1'b1, 3'b001, 1'b0); check_all("t2d", 0, 1, 0, 0, 0, 1, 1, 1);

        // T3: bad one-hot words while locked
        step(1'b1, 3'b011, 1'b0); check_all("t3a", 0, 0, 1, 0, 1, 0, 1, 0);
        step(1'b1, 3'b000, 1'b0); check_all("t3b", 0, 0, 1, 0, 1, 0, 1, 0);
        step(1'b0, 3'b000, 1'b1); check_all("t3clr", 0, 0, 0, 0, 0, 0, 1, 0);

        // T4: sequence skip, then re-lock
        step(1'b1, 3'b001, 1'b0); check_all("t4a", 0, 1, 0, 0, 0, 0, 1, 1);
        step(1'b1, 3'b100, 1'b0); check_all("t4b", 0, 0, 0, 1, 1, 0, 1, 0);
        step(1'b1, 3'b010, 1'b0); check_all("t4c", 1, 1, 0, 0, 1, 0, 1, 1);
        step(1'b1, 3'b100, 1'b0); check_all("t4d", 2, 1, 0, 0, 1, 0, 1, 1);

        // T5: gap in in_valid holds everything
        step(1'b1, 3'b001, 1'b0); check_all("t5a", 0, 1, 0, 0, 1, 1, 2, 1);
        step(1'b1, 3'b010, 1'b0); check_all("t5b", 1, 1, 0, 0, 1, 0, 2, 1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 3'b111, 1'b0); check_all("t5gap", 1, 0, 0, 0, 1, 0, 2, 1);
        end
        step(1'b1, 3'b100, 1'b0); check_all("t5c", 2, 1, 0, 0, 1, 0, 2, 1);

        // T1: asynchronous reset mid-cycle
        #2 rst = 1'b1;
        #1 check_all("t1rst", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 3'b001, 1'b0); check_all("t1a", 0, 1, 0, 0, 0, 0, 0, 1);

        // T6: five laps with a 2-bit counter
        for (int lap = 1; lap <= 5; lap++) begin
            step(1'b1, 3'b010, 1'b0); check("t6.idx1", 32'(idx_out), 32'd1);
            step(1'b1, 3'b100, 1'b0); check("t6.lap0", 32'(lap_pulse), 32'd0);
            step(1'b1, 3'b001, 1'b0);
            check("t6.lap", 32'(lap_pulse), 32'd1);
            check("t6.cnt", 32'(lap_count), 32'(lap % 4));
        end
        // Stalled ring with simultaneous clr_err: set wins
        step(1'b1, 3'b001, 1'b1); check_all("t6clr", 0, 0, 0, 1, 1, 0, 1, 0);
        step(1'b0, 3'b000, 1'b1); check_all("t6clr2", 0, 0, 0, 0, 0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
